// File: rtl/bank_reader.sv
// bank_reader: reads SIZE RAM banks in parallel, one shared address per cycle,
// and streams each bank line out through a 2-entry valid/ready FIFO.
// Optional feature macro: BANK_READER_LAST_EN adds the m_last output.
//
// Output handshake: a beat transfers on a rising edge where m_valid and
// m_ready are both high; while m_valid=1 and m_ready=0 the beat (m_data,
// m_valid, m_last) holds unchanged until it transfers.
module bank_reader #(
    parameter int SIZE    = 32,
    parameter int WIDTH   = 16,
    parameter int ADDRESS = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDRESS-1:0]      base_addr,
    input  logic [ADDRESS:0]        len,
    output logic                    busy,
    output logic                    done,
    output logic [SIZE-1:0]         enb,
    output logic [SIZE-1:0]         web,
    output logic [ADDRESS-1:0]      addrb,
    input  logic [SIZE*WIDTH-1:0]   doutb,
    output logic                    m_valid,
    input  logic                    m_ready,
`ifdef BANK_READER_LAST_EN
    output logic                    m_last,
`endif
    output logic [SIZE*WIDTH-1:0]   m_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDRESS:0]   CNT_ONE  = {{ADDRESS{1'b0}}, 1'b1};
    localparam logic [ADDRESS-1:0] ADDR_ONE = {{(ADDRESS-1){1'b0}}, 1'b1};

    // Current FSM state; kept as a named signal so checkers can bind to it.
    state_t state;
    state_t state_next;

    logic [ADDRESS-1:0]    addr_q;      // address of the next read to issue
    logic [ADDRESS:0]      rd_left;     // reads still to issue
    logic [ADDRESS:0]      beats_left;  // beats still to transfer
    logic                  pipe;        // read sampled by the RAM, data on doutb now
    logic [SIZE*WIDTH-1:0] fifo_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;

    logic pop;
    logic room;
    logic issue;
    logic accept;
    logic accept_run;
    logic last_issue;
    logic last_pop;

    // Handshake and admission terms shared by the FSM and the datapath.
    always_comb begin
        pop        = m_valid && m_ready;
        // Entries held + data already returning - a beat leaving now must stay
        // below 2, so the next-cycle capture of this read always finds room.
        room       = ({1'b0, count} + {2'b00, pipe}) < (3'd2 + {2'b00, pop});
        accept     = (state == IDLE) && start;
        accept_run = accept && (len != '0);
        last_issue = issue && (rd_left == CNT_ONE);
        last_pop   = pop && (beats_left == CNT_ONE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: RUN while reads remain, DRAIN until the last beat leaves.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_run) state_next = RUN;
            RUN:     if (last_issue) state_next = DRAIN;
            DRAIN:   if (last_pop)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: busy flag and the read enable broadcast to every bank.
    always_comb begin
        busy  = (state != IDLE);
        issue = (state == RUN) && room;
        enb   = {SIZE{issue}};
    end

    assign web     = '0;
    assign addrb   = addr_q;
    assign m_valid = (count != 2'd0);
    assign m_data  = fifo_mem[rd_ptr];

`ifdef BANK_READER_LAST_EN
    // The head beat is the final one exactly when one beat remains to transfer.
    assign m_last = m_valid && (beats_left == CNT_ONE);
`endif

    // Burst bookkeeping: address walk, read/beat counters, done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            rd_left    <= '0;
            beats_left <= '0;
            pipe       <= 1'b0;
            done       <= 1'b0;
        end else begin
            pipe <= issue;
            done <= last_pop || (accept && (len == '0));
            if (accept_run) begin
                addr_q     <= base_addr;
                rd_left    <= len;
                beats_left <= len;
            end else begin
                if (issue) begin
                    addr_q  <= addr_q + ADDR_ONE;
                    rd_left <= rd_left - CNT_ONE;
                end
                if (pop) begin
                    beats_left <= beats_left - CNT_ONE;
                end
            end
        end
    end

    // Two-entry output FIFO fed by RAM data one cycle after the RAM sampled enb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (pipe) begin
                fifo_mem[wr_ptr] <= doutb;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, pipe} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_bank_reader.sv
// Testbench for bank_reader: RAM model, queue-based reference of the burst
// (expected addresses and bank lines), directed and randomized scenarios.
module tb_bank_reader;

    localparam int SIZE    = 32;
    localparam int WIDTH   = 16;
    localparam int ADDRESS = 10;
    localparam int DW      = SIZE * WIDTH;
    localparam int DEPTH   = 1 << ADDRESS;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [ADDRESS-1:0] base_addr = '0;
    logic [ADDRESS:0]   len = '0;
    logic               busy;
    logic               done;
    logic [SIZE-1:0]    enb;
    logic [SIZE-1:0]    web;
    logic [ADDRESS-1:0] addrb;
    logic [DW-1:0]      doutb = '0;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic [DW-1:0]      m_data;
`ifdef BANK_READER_LAST_EN
    logic               m_last;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] salt = 16'h5a3c;

    bank_reader #(.SIZE(SIZE), .WIDTH(WIDTH), .ADDRESS(ADDRESS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .enb       (enb),
        .web       (web),
        .addrb     (addrb),
        .doutb     (doutb),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
`ifdef BANK_READER_LAST_EN
        .m_last    (m_last),
`endif
        .m_data    (m_data)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- RAM model ----------------
    function automatic logic [WIDTH-1:0] ram_word(input int bank, input int addr);
        int v;
        v = (addr * 40503) ^ (bank * 9973) ^ int'(salt);
        return WIDTH'(v);
    endfunction

    function automatic logic [DW-1:0] ram_line(input int addr);
        logic [DW-1:0] line;
        line = '0;
        for (int i = 0; i < SIZE; i++) line[i*WIDTH +: WIDTH] = ram_word(i, addr);
        return line;
    endfunction

    // Synchronous read: data appears the cycle after the RAM samples enb.
    always @(posedge clk) begin
        if (enb[0] === 1'b1) doutb <= ram_line(int'(addrb));
    end

    // ---------------- helpers ----------------
    task automatic check_all_zero(input string tag);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || enb !== '0 || web !== '0 || addrb !== '0 ||
            m_valid !== 1'b0 || m_data !== '0) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b enb=%h web=%h addrb=%h m_valid=%b m_data_nonzero=%b, required all 0",
                     tag, busy, done, enb, web, addrb, m_valid, (m_data != '0));
        end
`ifdef BANK_READER_LAST_EN
        checks++;
        if (m_last !== 1'b0) begin
            errors++;
            $display("FAIL %s_m_last: got %b, required 0", tag, m_last);
        end
`endif
    endtask

    // One burst. mode 0: m_ready=1; mode 1: random m_ready plus stray starts;
    // mode 2: m_ready low for the first 10 cycles. timed: check exact
    // full-rate cycle positions. pre_started: start was already driven in the
    // previous cycle. chain: drive the next start in the predicted done cycle.
    task automatic run_burst(input int base, input int n, input int mode, input bit timed,
                             input bit pre_started, input bit chain,
                             input int chain_base, input int chain_len);
        logic [DW-1:0] exp_q[$];
        int            addr_q[$];
        logic [DW-1:0] prev_data;
        logic [DW-1:0] e;
        bit            prev_stall;
        bit            finished;
        bit            exp_done;
        int            last_xfer;
        int            stall_reads;
        int            a;
        int            c;

        for (int k = 0; k < n; k++) begin
            a = (base + k) % DEPTH;
            addr_q.push_back(a);
            exp_q.push_back(ram_line(a));
        end
        if (!pre_started) begin
            @(posedge clk); #1;
            start     = 1'b1;
            base_addr = ADDRESS'(base);
            len       = (ADDRESS+1)'(n);
            m_ready   = 1'b0;
        end
        prev_stall  = 1'b0;
        prev_data   = '0;
        finished    = 1'b0;
        last_xfer   = -10;
        stall_reads = 0;
        c           = 0;
        while (!finished && c < 400) begin
            @(posedge clk); #1;
            start = 1'b0;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 3) != 0);
                default: m_ready = (c >= 10);
            endcase
            if (mode == 1 && exp_q.size() > 0 && $urandom_range(0, 7) == 0) begin
                start     = 1'b1;
                base_addr = ADDRESS'($urandom);
                len       = (ADDRESS+1)'($urandom_range(1, 8));
            end
            if (chain && c == n + 2) begin
                start     = 1'b1;
                base_addr = ADDRESS'(chain_base);
                len       = (ADDRESS+1)'(chain_len);
            end
            @(negedge clk);

            checks++;
            if (enb !== {SIZE{enb[0]}} || web !== '0) begin
                errors++;
                $display("FAIL bank_enables c=%0d: enb=%h web=%h, required all-equal enb and zero web", c, enb, web);
            end
            if (timed) begin
                checks++;
                if (enb[0] !== (c < n)) begin
                    errors++;
                    $display("FAIL enb_timing c=%0d: got %b, required %b", c, enb[0], (c < n));
                end
                checks++;
                if (m_valid !== (c >= 2 && c < n + 2)) begin
                    errors++;
                    $display("FAIL valid_timing c=%0d: got %b, required %b", c, m_valid, (c >= 2 && c < n + 2));
                end
            end
            if (enb[0] === 1'b1) begin
                if (mode == 2 && c < 10) stall_reads++;
                checks++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_read c=%0d: addrb=%h, required no read", c, addrb);
                end else begin
                    a = addr_q.pop_front();
                    if (addrb !== ADDRESS'(a)) begin
                        errors++;
                        $display("FAIL read_addr c=%0d: got %h, required %h", c, addrb, ADDRESS'(a));
                    end
                end
            end
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold_stable c=%0d: m_valid=%b data_changed=%b, required 1 and unchanged",
                             c, m_valid, (m_data !== prev_data));
                end
            end
`ifdef BANK_READER_LAST_EN
            checks++;
            if (m_last !== (m_valid === 1'b1 && exp_q.size() == 1)) begin
                errors++;
                $display("FAIL m_last c=%0d: got %b, required %b", c, m_last, (m_valid === 1'b1 && exp_q.size() == 1));
            end
`endif
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat c=%0d: got %h, required no beat", c, m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        errors++;
                        $display("FAIL beat_data c=%0d: got %h, required %h", c, m_data, e);
                    end
                end
                last_xfer = c;
            end
            exp_done = (exp_q.size() == 0) && (last_xfer == c - 1);
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL done c=%0d: got %b, required %b", c, done, exp_done);
            end
            checks++;
            if (busy !== !exp_done) begin
                errors++;
                $display("FAIL busy c=%0d: got %b, required %b", c, busy, !exp_done);
            end
            finished   = (done === 1'b1) || exp_done;
            prev_stall = (m_valid === 1'b1) && (m_ready !== 1'b1);
            prev_data  = m_data;
            c++;
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL burst_timeout: got no done in %0d cycles, required done", c);
        end
        checks++;
        if (addr_q.size() != 0) begin
            errors++;
            $display("FAIL missing_reads: got %0d reads short, required 0", addr_q.size());
        end
        if (mode == 2) begin
            checks++;
            if (stall_reads > 2) begin
                errors++;
                $display("FAIL stall_reads: got %0d, required at most 2", stall_reads);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("after_release");
    endtask

    task automatic test_basic();
        run_burst(32'h010, 4, 0, 1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_wrap();
        run_burst(32'h3FE, 4, 0, 1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_stall();
        salt = 16'($urandom);
        run_burst(int'($urandom_range(0, DEPTH - 1)), 8, 2, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_zero_len();
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = ADDRESS'($urandom);
        len       = '0;
        m_ready   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            checks++;
            if (done !== (c == 0) || busy !== 1'b0 || enb !== '0 || m_valid !== 1'b0) begin
                errors++;
                $display("FAIL zero_len c=%0d: done=%b busy=%b enb=%h m_valid=%b, required done=%b and others 0",
                         c, done, busy, enb, m_valid, (c == 0));
            end
        end
    endtask

    task automatic test_back_to_back();
        int b1;
        int b2;
        b1 = int'($urandom_range(0, DEPTH - 1));
        b2 = int'($urandom_range(0, DEPTH - 1));
        run_burst(b1, 3, 0, 1'b1, 1'b0, 1'b1, b2, 5);
        run_burst(b2, 5, 0, 1'b1, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            salt = 16'($urandom);
            run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 20)), 1,
                      1'b0, 1'b0, 1'b0, 0, 0);
        end
        run_burst(int'($urandom_range(DEPTH - 8, DEPTH - 1)), 40, 1, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mid_burst();
        int base;
        int beats;
        int c;
        base  = int'($urandom_range(0, DEPTH - 1));
        beats = 0;
        c     = 0;
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = ADDRESS'(base);
        len       = 11'd16;
        m_ready   = 1'b1;
        while (beats < 3 && c < 50) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (m_valid === 1'b1) begin
                checks++;
                if (m_data !== ram_line((base + beats) % DEPTH)) begin
                    errors++;
                    $display("FAIL mid_burst_data beat=%0d: got %h, required %h",
                             beats, m_data, ram_line((base + beats) % DEPTH));
                end
                beats++;
            end
            c++;
        end
        checks++;
        if (beats < 3) begin
            errors++;
            $display("FAIL mid_burst_timeout: got %0d beats, required 3", beats);
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_held");
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || enb !== '0 || m_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_reset k=%0d: done=%b busy=%b enb=%h m_valid=%b, required all 0",
                         k, done, busy, enb, m_valid);
            end
        end
        salt = 16'($urandom);
        run_burst(int'($urandom_range(0, DEPTH - 1)), 2, 0, 1'b1, 1'b0, 1'b0, 0, 0);
    endtask

`ifdef BANK_READER_LAST_EN
    task automatic test_last();
        run_burst(int'($urandom_range(0, DEPTH - 1)), 3, 0, 1'b1, 1'b0, 1'b0, 0, 0);
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_zero_len();
        test_back_to_back();
        test_random();
        test_reset_mid_burst();
`ifdef BANK_READER_LAST_EN
        test_last();
`endif
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bank_reader.md
BANK_READER -- requirements
Module: bank_reader

Interface
REQ-001 SHALL have parameter SIZE, default 32, giving the number of RAM banks read in parallel.
REQ-002 SHALL have parameter WIDTH, default 16, giving the bits per bank word.
REQ-003 SHALL have parameter ADDRESS, default 10, giving the bank address bits (depth 2**ADDRESS).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit: launches a read burst when idle.
REQ-007 SHALL have port base_addr, input, ADDRESS bits: first word address, sampled with start.
REQ-008 SHALL have port len, input, ADDRESS+1 bits: words per bank to read (0..2**ADDRESS), sampled with start.
REQ-009 SHALL have port busy, output, 1 bit: high from start acceptance until the done pulse.
REQ-010 SHALL have port done, output, 1 bit: single-cycle burst-complete pulse.
REQ-011 SHALL have port enb, output, SIZE bits: read enable broadcast to every bank (all bits equal).
REQ-012 SHALL have port web, output, SIZE bits: write enable, tied to all zero.
REQ-013 SHALL have port addrb, output, ADDRESS bits: read address shared by all banks.
REQ-014 SHALL have port doutb, input, SIZE*WIDTH bits: RAM read data, bank i at bits [i*WIDTH +: WIDTH], valid the cycle after enb.
REQ-015 SHALL have port m_valid, output, 1 bit: output beat valid.
REQ-016 SHALL have port m_ready, input, 1 bit: consumer accept.
REQ-017 SHALL have port m_data, output, SIZE*WIDTH bits: output beat, with the same bank packing as doutb.

Function
REQ-018 SHALL implement states IDLE, RUN and DRAIN; start with len>0 in IDLE moves to RUN and latches base_addr/len.
REQ-019 SHALL ignore start while not in IDLE.
REQ-020 SHALL pulse done one cycle after start when start arrives in IDLE with len=0, issuing no reads and never asserting busy.
REQ-021 SHALL issue read k (k=0..len-1) by asserting enb for exactly one cycle with addrb=(base_addr+k) mod 2**ADDRESS; the address wraps from 2**ADDRESS-1 to 0.
REQ-022 SHALL capture doutb into a 2-entry output FIFO on the clock edge after the edge that sampled enb.
REQ-023 SHALL issue a read only when FIFO occupancy plus reads in flight, minus a pop occurring this cycle, is less than 2; the FIFO therefore never overflows, and with m_ready held high it sustains one beat per cycle.
REQ-024 SHALL deliver the first beat with minimum latency: start sampled at edge N, enb high during cycle N..N+1, m_valid high after edge N+2.
REQ-025 SHALL hold m_data and m_valid stable while m_valid=1 and m_ready=0; a beat transfers when both are high.
REQ-026 SHALL emit beats in address order, exactly len beats per burst.
REQ-027 SHALL move RUN to DRAIN once the last read is issued, and DRAIN to IDLE on the last beat's transfer.
REQ-028 SHALL pulse done in the cycle after the last transfer, and deassert busy in that same cycle.
REQ-029 SHALL accept a new start in the cycle done is high.

Reset
REQ-030 SHALL on rst_n=0 immediately force: state IDLE, busy=0, done=0, enb=0, web=0, addrb=0, m_valid=0, m_data=0, FIFO empty, in-flight count 0.
REQ-031 SHALL on reset during a burst discard the burst entirely, including RAM data returning after reset release; there is no done pulse.

Configuration
REQ-032 SHALL, with macro BANK_READER_LAST_EN defined, add output m_last (1 bit), high with the final beat of each burst and reset to 0; without the macro, the port and its logic are absent.

Verification
REQ-033 SHALL test base_addr=0x010, len=4, m_ready=1: addrb 0x010..0x013 on consecutive cycles, 4 beats on consecutive cycles starting at edge N+2, done one cycle after the 4th beat.
REQ-034 SHALL test base_addr=0x3FE, len=4: addrb sequence 0x3FE, 0x3FF, 0x000, 0x001.
REQ-035 SHALL test len=8 with m_ready low for 10 cycles after start: at most 2 enb pulses, data held stable, all 8 beats correct and in order after m_ready rises.
REQ-036 SHALL test len=0: done pulses next cycle; busy, enb and m_valid stay 0.
REQ-037 SHALL test rst_n low mid-burst at beat 3 of len=16: all outputs are zero within the reset, and a later burst of len=2 returns exactly 2 correct beats.
REQ-038 SHALL test with BANK_READER_LAST_EN defined and len=3: m_last high only on the 3rd beat.
